poola1_stream: RTL and testbench
================================

Name: poola1_stream

Overview:
- Downstream neighbour of the first convolution data path: consumes its post-ReLU output stream (data_out_for_next) and performs 2x2 stride-2 max pooling on the fly.
- Writes pooled results straight into the next layer's per-filter IFM banks, one bank per filter, with address plus one-hot write enable.
- Uses a half-row line buffer, so no full feature-map storage is needed.

Parameters:
- DATA_WIDTH, 32, width of a data word (fixed-point or float bit pattern).
- OFM_SIZE, 30, side of each incoming conv feature map.
- NUMBER_OF_FILTERS, 8, number of feature maps streamed back to back; also the number of destination banks.
- POOL_SIZE_OUT, OFM_SIZE/2 (floor), side of each pooled map.
- ADDRESS_SIZE_NEXT, $clog2(POOL_SIZE_OUT*POOL_SIZE_OUT), width of the destination bank address.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that arms the block for a new layer pass.
- data_in  in  DATA_WIDTH  conv/ReLU output pixel.
- data_valid  in  1  data_in is valid this cycle.
- out_data  out  DATA_WIDTH  pooled pixel.
- out_address  out  ADDRESS_SIZE_NEXT  write address in the destination bank.
- out_enable_write  out  NUMBER_OF_FILTERS  one-hot write strobe; bit f selects the bank for filter f.
- map_done  out  1  one-cycle pulse after the last write of each filter map.
- pool_done  out  1  one-cycle pulse after the last write of the last filter.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE and clears all counters. Output values after reset: out_data=0, out_address=0, out_enable_write=0, map_done=0, pool_done=0, busy=0. The line buffer contents are don't-care.
- Input order: pixels arrive in raster order (row-major), one full map per filter, filter 0 first. data_valid may drop for any number of cycles; counters advance only on valid pixels.
- Counters: col (0..OFM_SIZE-1), row (0..OFM_SIZE-1), filt (0..NUMBER_OF_FILTERS-1), wr_addr (0..POOL_SIZE_OUT^2-1). col wraps to 0 and increments row; row wraps to 0 and increments filt; wr_addr resets to 0 on each new filter.
- Comparison: unsigned magnitude compare of the full word. Inputs are post-ReLU (non-negative), so this ordering is correct for both the fixed-point and the IEEE-float codings. On a tie, the earlier pixel is kept.
- Even column: hold_r <= data_in.
- Odd column: hmax = max(hold_r, data_in).
  - Even row: lb[col>>1] <= hmax.
  - Odd row: the block registers out_data <= max(lb[col>>1], hmax), out_address <= wr_addr, and out_enable_write <= (1<<filt). wr_addr then increments.
- Latency: the write strobe is asserted exactly 1 cycle after the odd-row/odd-column input, for exactly 1 cycle. No other cycle asserts out_enable_write.
- Odd OFM_SIZE: the last column and the last row of each map are consumed (counters advance) but never written. POOL_SIZE_OUT uses floor.
- The line buffer is never read and written in the same cycle, because even rows only write and odd rows only read.
- State machine:
  - IDLE: busy=0; data_valid is ignored. start moves to RUN and clears all counters.
  - RUN: busy=1. After the final valid pixel (filt=NUMBER_OF_FILTERS-1, row=col=OFM_SIZE-1), move to DONE.
  - DONE: pool_done=1 for one cycle, then return to IDLE.
- map_done pulses in the same cycle as the last write of each map. On the last filter it coincides with the pool_done cycle.
- start is ignored while in RUN or DONE. A start in the same cycle as a valid pixel while in IDLE arms the block, and that pixel is ignored.
- Reset asserted mid-map aborts immediately. No partial write completes after reset deasserts.

Decomposition:
- Shared package: POOL_SIZE_OUT and ADDRESS_SIZE_NEXT derivation functions, and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One natural sub-module: pool_line_buffer.
  - Register array of POOL_SIZE_OUT x DATA_WIDTH.
  - Synchronous write, combinational read.
  - Ports: clk, wr_en, wr_addr, wr_data, rd_addr, rd_data.
  - Does not use reset.

Test Plan (OFM_SIZE=4, NUMBER_OF_FILTERS=2 unless noted):
- Reset values: hold reset=0 and drive data_valid=1 -> every output is 0 and busy=0; releasing reset leaves the block in IDLE.
- Filter 0 single map: start, then feed pixels 1..16 contiguously -> 4 writes of out_data=6,8,14,16 at out_address 0,1,2,3 with out_enable_write=2'b01, each 1 cycle after inputs 6,8,14,16. map_done is asserted with the 4th write.
- Valid bubbles: same stream with data_valid low for 3 cycles between every pixel -> identical data, addresses and strobes, only time-shifted.
- Two filters, tie and ordering: filter 1 map all 5s, except value 9 at row3,col0 -> filter 1 writes are 5,5,9,5 at addresses 0..3 with strobe 2'b10; pool_done pulses once after the last write.
- OFM_SIZE=5: feed 25 pixels numbered 1..25 -> 4 writes of 7,9,17,19; row 4 and column 4 never produce a write; pool_done pulses after pixel 25.
- Mid-map reset and start handling: assert reset after 6 pixels of filter 0 -> no strobe ever follows. Then start and feed a fresh map -> writes restart at address 0. A start pulse during RUN -> counters unchanged.

Source files
------------

// File: rtl/poola1_stream_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | poola1_stream_pkg                                                       |
// | Geometry helpers and FSM encoding for the 2x2 stride-2 pooling stream.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package poola1_stream_pkg;

  function automatic int pool_size_out(input int ofm);
    return ofm / 2;
  endfunction

  // Clamped to 1 so degenerate sizes still give a legal vector width.
  function automatic int addr_width(input int pool);
    return (pool * pool > 1) ? $clog2(pool * pool) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/poola1_stream_line_buffer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pool_line_buffer                                                        |
// | Half-row store of horizontal maxima; sync write, combinational read.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module pool_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 15,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/poola1_stream.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | poola1_stream                                                           |
// | On-the-fly 2x2 stride-2 max pooling into per-filter IFM banks.          |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module poola1_stream
  import poola1_stream_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int OFM_SIZE          = 30,
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int POOL_SIZE_OUT     = pool_size_out(OFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT = addr_width(POOL_SIZE_OUT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         data_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [ADDRESS_SIZE_NEXT-1:0] out_address,
  output logic [NUMBER_OF_FILTERS-1:0] out_enable_write,
  output logic                         map_done,
  output logic                         pool_done,
  output logic                         busy
);

  localparam int c_CNT_W  = cnt_width(OFM_SIZE);
  localparam int c_FILT_W = cnt_width(NUMBER_OF_FILTERS);
  localparam int c_LB_AW  = cnt_width(POOL_SIZE_OUT);
  localparam logic [c_CNT_W-1:0]           c_LAST_POS  = c_CNT_W'(OFM_SIZE - 1);
  localparam logic [c_FILT_W-1:0]          c_LAST_FILT = c_FILT_W'(NUMBER_OF_FILTERS - 1);
  localparam logic [ADDRESS_SIZE_NEXT-1:0] c_LAST_ADDR =
    ADDRESS_SIZE_NEXT'(POOL_SIZE_OUT * POOL_SIZE_OUT - 1);

  state_t                         r_state;
  state_t                         w_state_next;
  logic [c_CNT_W-1:0]             r_col;
  logic [c_CNT_W-1:0]             r_row;
  logic [c_FILT_W-1:0]            r_filt;
  logic [ADDRESS_SIZE_NEXT-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]          r_hold;
  logic [DATA_WIDTH-1:0]          r_out_data;
  logic [ADDRESS_SIZE_NEXT-1:0]   r_out_address;
  logic [NUMBER_OF_FILTERS-1:0]   r_out_we;
  logic                           r_map_done;
  logic [DATA_WIDTH-1:0]          w_hmax;
  logic [DATA_WIDTH-1:0]          w_vmax;
  logic [DATA_WIDTH-1:0]          w_lb_rd;
  logic [c_LB_AW-1:0]             w_lb_addr;
  logic [NUMBER_OF_FILTERS-1:0]   w_onehot;
  logic                           w_pix;
  logic                           w_col_last;
  logic                           w_row_last;
  logic                           w_last_pix;
  logic                           w_lb_wr;
  logic                           w_emit;
  logic                           w_busy;
  logic                           w_pool_done;

  assign w_pix      = (r_state == ST_RUN) && data_valid;
  assign w_col_last = (r_col == c_LAST_POS);
  assign w_row_last = (r_row == c_LAST_POS);
  assign w_last_pix = w_pix && w_col_last && w_row_last && (r_filt == c_LAST_FILT);

  // Strict greater-than keeps the earlier pixel on ties in both directions.
  assign w_hmax    = (data_in > r_hold) ? data_in : r_hold;
  assign w_vmax    = (w_hmax > w_lb_rd) ? w_hmax : w_lb_rd;
  assign w_lb_addr = c_LB_AW'(r_col >> 1);
  assign w_lb_wr   = w_pix && r_col[0] && !r_row[0];
  assign w_emit    = w_pix && r_col[0] && r_row[0];

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
      w_onehot[i] = (r_filt == c_FILT_W'(i));
    end
  end

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (POOL_SIZE_OUT),
    .ADDR_WIDTH (c_LB_AW)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (w_lb_wr),
    .wr_addr (w_lb_addr),
    .wr_data (w_hmax),
    .rd_addr (w_lb_addr),
    .rd_data (w_lb_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_pool_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last_pix) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_pool_done  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col     <= '0;
      r_row     <= '0;
      r_filt    <= '0;
      r_wr_addr <= '0;
      r_hold    <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_col     <= '0;
      r_row     <= '0;
      r_filt    <= '0;
      r_wr_addr <= '0;
    end else if (w_pix) begin
      if (!r_col[0]) begin
        r_hold <= data_in;
      end
      if (w_emit) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      // Map boundary overrides the address increment above.
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row     <= '0;
          r_wr_addr <= '0;
          r_filt    <= (r_filt == c_LAST_FILT) ? '0 : r_filt + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data    <= '0;
      r_out_address <= '0;
      r_out_we      <= '0;
      r_map_done    <= 1'b0;
    end else begin
      r_out_we   <= '0;
      r_map_done <= 1'b0;
      if (w_emit) begin
        r_out_data    <= w_vmax;
        r_out_address <= r_wr_addr;
        r_out_we      <= w_onehot;
        r_map_done    <= (r_wr_addr == c_LAST_ADDR);
      end
    end
  end

  assign out_data         = r_out_data;
  assign out_address      = r_out_address;
  assign out_enable_write = r_out_we;
  assign map_done         = r_map_done;
  assign pool_done        = w_pool_done;
  assign busy             = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_poola1_stream.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_poola1_stream                                                        |
// | Self-checking bench: 4x4/2-filter and 5x5/1-filter instances.           |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_poola1_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;

  always #5 clk = ~clk;

  logic [31:0] od4, od5;
  logic [1:0]  oa4, oa5;
  logic [1:0]  we4;
  logic [0:0]  we5;
  logic        md4, pd4, busy4, md5, pd5, busy5;

  poola1_stream #(.DATA_WIDTH(32), .OFM_SIZE(4), .NUMBER_OF_FILTERS(2)) dut4 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
    .out_data(od4), .out_address(oa4), .out_enable_write(we4),
    .map_done(md4), .pool_done(pd4), .busy(busy4)
  );

  poola1_stream #(.DATA_WIDTH(32), .OFM_SIZE(5), .NUMBER_OF_FILTERS(1)) dut5 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
    .out_data(od5), .out_address(oa5), .out_enable_write(we5),
    .map_done(md5), .pool_done(pd5), .busy(busy5)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  a;
    logic [1:0]  we;
    logic        md;
    int          cyc;
  } wr_t;

  wr_t         obs4_q[$];
  wr_t         obs5_q[$];
  wr_t         exp_q[$];
  wr_t         mon4, mon5;
  int          pd4_q[$];
  int          pd5_q[$];
  int          md4_cnt = 0;
  int          md5_cnt = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          last_in_cyc = 0;
  logic [31:0] map_px [0:24];
  int          in_cyc [0:24];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we4 != 2'b00) begin
      mon4.d = od4; mon4.a = oa4; mon4.we = we4; mon4.md = md4; mon4.cyc = cyc;
      obs4_q.push_back(mon4);
    end
    if (md4) md4_cnt++;
    if (pd4) pd4_q.push_back(cyc);
    if (we5 != 1'b0) begin
      mon5.d = od5; mon5.a = oa5; mon5.we = {1'b0, we5}; mon5.md = md5; mon5.cyc = cyc;
      obs5_q.push_back(mon5);
    end
    if (md5) md5_cnt++;
    if (pd5) pd5_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    obs4_q.delete(); obs5_q.delete(); exp_q.delete();
    pd4_q.delete(); pd5_q.delete();
    md4_cnt = 0; md5_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic fill_seq(input int ofm);
    for (int i = 0; i < ofm * ofm; i++) map_px[i] = 32'(i + 1);
  endtask

  task automatic fill_rand(input int ofm, input logic [31:0] maxv);
    for (int i = 0; i < ofm * ofm; i++) map_px[i] = $urandom_range(0, maxv);
  endtask

  // gap < 0 selects a random 0..3 idle cycles between pixels.
  task automatic feed_map(input int ofm, input int gap, input int start_at);
    int g;
    for (int i = 0; i < ofm * ofm; i++) begin
      data_in    = map_px[i];
      data_valid = 1'b1;
      start      = (i == start_at);
      in_cyc[i]  = cyc;
      tick();
      last_in_cyc = in_cyc[i];
      data_valid  = 1'b0;
      start       = 1'b0;
      data_in     = $urandom;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) tick();
    end
  endtask

  // Reference: each pooled cell is the max of its 2x2 window, written one
  // cycle after its bottom-right pixel; cells are addressed row-major.
  task automatic model_map(input int ofm, input int filt);
    int p;
    wr_t w;
    logic [31:0] m;
    p = ofm / 2;
    for (int pr = 0; pr < p; pr++) begin
      for (int pc = 0; pc < p; pc++) begin
        m = 32'd0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (map_px[(2*pr+dr)*ofm + 2*pc+dc] > m) m = map_px[(2*pr+dr)*ofm + 2*pc+dc];
        w.d   = m;
        w.a   = 2'(pr * p + pc);
        w.we  = 2'(1 << filt);
        w.md  = (pr * p + pc == p * p - 1);
        w.cyc = in_cyc[(2*pr+1)*ofm + 2*pc+1] + 1;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; data_valid = 1'b1; data_in = $urandom;
    repeat (3) tick();
    n_checks++;
    if ({od4, oa4, we4, md4, pd4, busy4} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs4: got d=%0h a=%0d we=%b md=%b pd=%b busy=%b, expected all 0", od4, oa4, we4, md4, pd4, busy4);
    end
    n_checks++;
    if ({od5, oa5, we5, md5, pd5, busy5} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs5: got d=%0h a=%0d we=%b md=%b pd=%b busy=%b, expected all 0", od5, oa5, we5, md5, pd5, busy5);
    end
    start = 1'b0;
    reset = 1'b1;
    clear_q();
    for (int i = 0; i < 6; i++) begin
      data_in = $urandom; data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (busy4 !== 1'b0 || obs4_q.size() != 0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got busy=%b writes=%0d, expected busy=0 writes=0", busy4, obs4_q.size());
    end
  endtask

  task automatic test_single_map();
    logic [31:0] ref_v [4];
    ref_v = '{32'd6, 32'd8, 32'd14, 32'd16};
    clear_q();
    fill_seq(4);
    do_start();
    n_checks++;
    if (busy4 !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_after_start: got %b, expected 1", busy4);
    end
    feed_map(4, 0, -1);
    model_map(4, 0);
    repeat (3) tick();
    n_checks++;
    if (obs4_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL single_map_count: got %0d writes, expected %0d", obs4_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs4_q[i].d !== exp_q[i].d || obs4_q[i].a !== exp_q[i].a || obs4_q[i].we !== exp_q[i].we ||
            obs4_q[i].md !== exp_q[i].md || obs4_q[i].cyc != exp_q[i].cyc || obs4_q[i].d !== ref_v[i]) begin
          n_errors++;
          $display("FAIL single_map_wr%0d: got d=%0d a=%0d we=%b md=%b cyc=%0d, expected d=%0d a=%0d we=%b md=%b cyc=%0d",
                   i, obs4_q[i].d, obs4_q[i].a, obs4_q[i].we, obs4_q[i].md, obs4_q[i].cyc,
                   exp_q[i].d, exp_q[i].a, exp_q[i].we, exp_q[i].md, exp_q[i].cyc);
        end
      end
    end
    n_checks++;
    if (md4_cnt != 1 || pd4_q.size() != 0 || busy4 !== 1'b1) begin
      n_errors++;
      $display("FAIL single_map_flags: got map_done=%0d pool_done=%0d busy=%b, expected 1 0 1", md4_cnt, pd4_q.size(), busy4);
    end
  endtask

  task automatic test_two_filters();
    logic [31:0] ref_v [4];
    ref_v = '{32'd5, 32'd5, 32'd9, 32'd5};
    clear_q();
    for (int i = 0; i < 16; i++) map_px[i] = 32'd5;
    map_px[12] = 32'd9;
    feed_map(4, 0, -1);
    model_map(4, 1);
    repeat (3) tick();
    n_checks++;
    if (obs4_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL two_filters_count: got %0d writes, expected %0d", obs4_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs4_q[i].d !== exp_q[i].d || obs4_q[i].a !== exp_q[i].a || obs4_q[i].we !== exp_q[i].we ||
            obs4_q[i].md !== exp_q[i].md || obs4_q[i].cyc != exp_q[i].cyc || obs4_q[i].d !== ref_v[i]) begin
          n_errors++;
          $display("FAIL two_filters_wr%0d: got d=%0d a=%0d we=%b md=%b cyc=%0d, expected d=%0d a=%0d we=%b md=%b cyc=%0d",
                   i, obs4_q[i].d, obs4_q[i].a, obs4_q[i].we, obs4_q[i].md, obs4_q[i].cyc,
                   exp_q[i].d, exp_q[i].a, exp_q[i].we, exp_q[i].md, exp_q[i].cyc);
        end
      end
    end
    n_checks++;
    if (pd4_q.size() != 1 || md4_cnt != 1) begin
      n_errors++;
      $display("FAIL two_filters_done_count: got pool_done=%0d map_done=%0d, expected 1 1", pd4_q.size(), md4_cnt);
    end else if (pd4_q[0] != last_in_cyc + 1 || busy4 !== 1'b0) begin
      n_errors++;
      $display("FAIL two_filters_done_time: got pool_done cyc=%0d busy=%b, expected cyc=%0d busy=0", pd4_q[0], busy4, last_in_cyc + 1);
    end
  endtask

  // passes: each is a full two-filter layer; gap<0 gives random bubbles.
  task automatic test_stream(input string name, input int passes, input int gap0, input int start_at);
    for (int p = 0; p < passes; p++) begin
      clear_q();
      do_start();
      if (p == 0 && gap0 >= 0) fill_seq(4); else fill_rand(4, (p % 2 == 0) ? 32'd3 : 32'hFFFF_FFFF);
      feed_map(4, (p == 0) ? gap0 : -1, start_at);
      model_map(4, 0);
      fill_rand(4, (p % 2 == 0) ? 32'hFFFF_FFFF : 32'd2);
      feed_map(4, -1, -1);
      model_map(4, 1);
      repeat (3) tick();
      n_checks++;
      if (obs4_q.size() != exp_q.size()) begin
        n_errors++;
        $display("FAIL %s_count pass%0d: got %0d writes, expected %0d", name, p, obs4_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (obs4_q[i].d !== exp_q[i].d || obs4_q[i].a !== exp_q[i].a || obs4_q[i].we !== exp_q[i].we ||
              obs4_q[i].md !== exp_q[i].md || obs4_q[i].cyc != exp_q[i].cyc) begin
            n_errors++;
            $display("FAIL %s_wr%0d pass%0d: got d=%0h a=%0d we=%b md=%b cyc=%0d, expected d=%0h a=%0d we=%b md=%b cyc=%0d",
                     name, i, p, obs4_q[i].d, obs4_q[i].a, obs4_q[i].we, obs4_q[i].md, obs4_q[i].cyc,
                     exp_q[i].d, exp_q[i].a, exp_q[i].we, exp_q[i].md, exp_q[i].cyc);
          end
        end
      end
      n_checks++;
      if (pd4_q.size() != 1 || md4_cnt != 2) begin
        n_errors++;
        $display("FAIL %s_done pass%0d: got pool_done=%0d map_done=%0d, expected 1 2", name, p, pd4_q.size(), md4_cnt);
      end else if (pd4_q[0] != last_in_cyc + 1) begin
        n_errors++;
        $display("FAIL %s_done_time pass%0d: got %0d, expected %0d", name, p, pd4_q[0], last_in_cyc + 1);
      end
    end
  endtask

  task automatic test_odd_size();
    logic [31:0] ref_v [4];
    ref_v = '{32'd7, 32'd9, 32'd17, 32'd19};
    pulse_reset();
    for (int p = 0; p < 2; p++) begin
      clear_q();
      if (p == 0) fill_seq(5); else fill_rand(5, 32'hFFFF_FFFF);
      do_start();
      feed_map(5, (p == 0) ? 0 : -1, -1);
      model_map(5, 0);
      repeat (3) tick();
      n_checks++;
      if (obs5_q.size() != exp_q.size()) begin
        n_errors++;
        $display("FAIL odd_size_count pass%0d: got %0d writes, expected %0d", p, obs5_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (obs5_q[i].d !== exp_q[i].d || obs5_q[i].a !== exp_q[i].a || obs5_q[i].we !== exp_q[i].we ||
              obs5_q[i].md !== exp_q[i].md || obs5_q[i].cyc != exp_q[i].cyc || (p == 0 && obs5_q[i].d !== ref_v[i])) begin
            n_errors++;
            $display("FAIL odd_size_wr%0d pass%0d: got d=%0h a=%0d we=%b md=%b cyc=%0d, expected d=%0h a=%0d we=%b md=%b cyc=%0d",
                     i, p, obs5_q[i].d, obs5_q[i].a, obs5_q[i].we, obs5_q[i].md, obs5_q[i].cyc,
                     exp_q[i].d, exp_q[i].a, exp_q[i].we, exp_q[i].md, exp_q[i].cyc);
          end
        end
      end
      n_checks++;
      if (pd5_q.size() != 1 || md5_cnt != 1) begin
        n_errors++;
        $display("FAIL odd_size_done pass%0d: got pool_done=%0d map_done=%0d, expected 1 1", p, pd5_q.size(), md5_cnt);
      end else if (pd5_q[0] != last_in_cyc + 1 || busy5 !== 1'b0) begin
        n_errors++;
        $display("FAIL odd_size_done_time pass%0d: got cyc=%0d busy=%b, expected cyc=%0d busy=0", p, pd5_q[0], busy5, last_in_cyc + 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    pulse_reset();
    clear_q();
    fill_rand(4, 32'hFFFF_FFFF);
    do_start();
    for (int i = 0; i < 5; i++) begin
      data_in = map_px[i]; data_valid = 1'b1;
      tick();
    end
    // Sixth pixel completes the first 2x2 window; reset lands before it is taken.
    data_in = map_px[5]; data_valid = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    data_valid = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (obs4_q.size() != 0 || busy4 !== 1'b0 || md4_cnt != 0) begin
      n_errors++;
      $display("FAIL reset_abort: got writes=%0d busy=%b map_done=%0d, expected 0 0 0", obs4_q.size(), busy4, md4_cnt);
    end
    clear_q();
    test_stream("restart", 1, -1, 7);
    n_checks++;
    if (obs4_q.size() == 0 || obs4_q[0].a !== 2'd0) begin
      n_errors++;
      $display("FAIL restart_first_addr: got writes=%0d, expected first write at address 0", obs4_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_map();
    test_two_filters();
    test_stream("bubbles", 1, 3, -1);
    test_stream("random", 4, -1, -1);
    test_odd_size();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
